gemm_tile_engine: RTL and testbench

- Memory-mapped tiled GEMM accelerator. Computes C[m][n] = sum over k of A[m][k]*B[k][n], with 8-bit unsigned operands and 32-bit accumulation.
- Software programs one tile job (up to 16x16x16) per launch over the system bus.
- The engine fetches A and B bytes from a shared 16-byte-wide scratch memory and writes C results back through the same port, four 32-bit words per beat.

---
 rtl/gemm_tile_engine.sv | 258 +++++++++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_engine.sv
// Memory-mapped tiled GEMM engine: C = A*B with 8-bit unsigned operands and 32-bit accumulators.
// One active job plus one pending slot; the B tile is buffered once, A is streamed one row at a time.
module gemm_tile_engine #(
    parameter int unsigned SYS_ROWS  = 16,
    parameter int unsigned SYS_COLS  = 16,
    parameter int unsigned TILE_M    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         system_bus_en,
    input  logic         system_bus_rdwr,
    input  logic [31:0]  system_bus_addr,
    input  logic [31:0]  system_bus_wr_data,
    output logic [31:0]  system_bus_rd_data,
    output logic         interface_en,
    output logic         interface_rdwr,
    output logic [31:0]  interface_addr,
    output logic [4:0]   interface_control,
    input  logic [127:0] interface_rd_data,
    output logic [127:0] interface_wr_data
);
    typedef enum logic [2:0] {S_IDLE, S_BREQ, S_BWAIT, S_AREQ, S_AWAIT, S_MAC, S_WB} state_t;

    state_t r_state, w_state_nxt;

    logic [31:0] r_reg_a, r_reg_b, r_reg_c, r_reg_as, r_reg_bs;
    logic [1:0]  r_reg_ctl;
    logic        r_p_vld, r_p_first, r_p_last;
    logic [31:0] r_p_a, r_p_b, r_p_c, r_p_as, r_p_bs;
    logic [4:0]  r_p_m, r_p_k, r_p_n;
    logic        r_j_first, r_j_last;
    logic [31:0] r_j_a, r_j_b, r_j_c, r_j_as, r_j_bs;
    logic [4:0]  r_j_m, r_j_k, r_j_n;
    logic [4:0]  r_cnt, r_row;
    logic [31:0] r_bus_rd;
    logic        r_if_en, r_if_rdwr, r_rd_vld;
    logic [31:0] r_if_addr;
    logic [4:0]  r_if_ctl;
    logic [127:0] r_if_wdata;

    logic [7:0]  r_bbuf [SYS_COLS][SYS_ROWS];
    logic [7:0]  r_a_row [SYS_COLS];
    logic [31:0] r_acc [TILE_M][SYS_ROWS];

    logic [31:0]  w_off;
    logic         w_wr, w_rd, w_launch, w_take, w_p_ok, w_done;
    logic         w_k_end, w_m_end, w_b_end, w_clr;
    logic [4:0]   w_beats, w_col, w_rem, w_nwords;
    logic [3:0]   w_brow;
    logic         w_req_en, w_req_rdwr;
    logic [31:0]  w_req_addr;
    logic [4:0]   w_req_ctl;
    logic [127:0] w_req_data;

    assign w_off    = system_bus_addr - BASE_ADDR;
    assign w_wr     = system_bus_en && system_bus_rdwr;
    assign w_rd     = system_bus_en && !system_bus_rdwr;
    assign w_launch = w_wr && (w_off == 32'd24) && (!r_p_vld || w_take);
    assign w_done   = (r_state == S_IDLE) && !r_p_vld && !r_if_en;
    assign w_p_ok   = (r_p_m != 5'd0) && ({1'b0, r_p_m} <= 6'(TILE_M)) &&
                      (r_p_k != 5'd0) && ({1'b0, r_p_k} <= 6'(SYS_COLS)) &&
                      (r_p_n != 5'd0) && ({1'b0, r_p_n} <= 6'(SYS_ROWS));

    assign w_k_end  = (r_cnt == r_j_k - 5'd1);
    assign w_m_end  = (r_row == r_j_m - 5'd1);
    assign w_beats  = 5'(({1'b0, r_j_n} + 6'd3) >> 2);
    assign w_b_end  = (r_cnt == w_beats - 5'd1);
    assign w_col    = {r_cnt[2:0], 2'b00};
    assign w_rem    = r_j_n - w_col;
    assign w_nwords = (w_rem > 5'd4) ? 5'd4 : w_rem;
    assign w_brow   = 4'(r_j_k - 5'd1 - r_cnt);
    assign w_clr    = r_j_first && (r_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and the memory request to be registered onto the interface next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_req_en    = 1'b0;
        w_req_rdwr  = 1'b0;
        w_req_addr  = 32'd0;
        w_req_ctl   = 5'd0;
        w_req_data  = 128'd0;
        case (r_state)
            S_IDLE: begin
                if (r_p_vld) begin
                    w_take = 1'b1;
                    if (w_p_ok) w_state_nxt = S_BREQ;
                end
            end
            S_BREQ: begin
                w_req_en    = 1'b1;
                w_req_addr  = r_j_b - 32'(r_cnt) * r_j_bs;
                w_req_ctl   = r_j_n;
                w_state_nxt = S_BWAIT;
            end
            S_BWAIT: if (r_rd_vld) w_state_nxt = w_k_end ? S_AREQ : S_BREQ;
            S_AREQ: begin
                w_req_en    = 1'b1;
                w_req_addr  = r_j_a + 32'(r_row) * r_j_as;
                w_req_ctl   = r_j_k;
                w_state_nxt = S_AWAIT;
            end
            S_AWAIT: if (r_rd_vld) w_state_nxt = S_MAC;
            S_MAC: begin
                if (w_k_end) begin
                    if (!w_m_end)     w_state_nxt = S_AREQ;
                    else if (r_j_last) w_state_nxt = S_WB;
                    else              w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                w_req_en   = 1'b1;
                w_req_rdwr = 1'b1;
                w_req_addr = r_j_c + ((32'(r_row) * r_j_bs + 32'(w_col)) << 2);
                w_req_ctl  = {w_nwords[2:0], 2'b00};
                for (int w = 0; w < 4; w++) begin
                    if (5'(w) < w_nwords)
                        w_req_data[32*w +: 32] = r_acc[r_row[3:0]][w_col[3:0] + 4'(w)];
                end
                if (w_b_end && w_m_end) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Register file, job queue and status reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_a <= '0; r_reg_b <= '0; r_reg_c <= '0; r_reg_as <= '0; r_reg_bs <= '0;
            r_reg_ctl <= '0;
            r_p_vld <= 1'b0; r_p_first <= 1'b0; r_p_last <= 1'b0;
            r_p_a <= '0; r_p_b <= '0; r_p_c <= '0; r_p_as <= '0; r_p_bs <= '0;
            r_p_m <= '0; r_p_k <= '0; r_p_n <= '0;
            r_bus_rd <= '0;
        end else begin
            if (w_wr) begin
                case (w_off)
                    32'd0:   r_reg_a   <= system_bus_wr_data;
                    32'd4:   r_reg_b   <= system_bus_wr_data;
                    32'd8:   r_reg_c   <= system_bus_wr_data;
                    32'd12:  r_reg_as  <= system_bus_wr_data;
                    32'd16:  r_reg_bs  <= system_bus_wr_data;
                    32'd20:  r_reg_ctl <= system_bus_wr_data[1:0];
                    default: ;
                endcase
            end
            if (w_launch) begin
                r_p_vld   <= 1'b1;
                r_p_a     <= r_reg_a;  r_p_b <= r_reg_b;  r_p_c <= r_reg_c;
                r_p_as    <= r_reg_as; r_p_bs <= r_reg_bs;
                r_p_first <= r_reg_ctl[1];
                r_p_last  <= r_reg_ctl[0];
                r_p_m     <= system_bus_wr_data[4:0];
                r_p_k     <= system_bus_wr_data[9:5];
                r_p_n     <= system_bus_wr_data[14:10];
            end else if (w_take) begin
                r_p_vld <= 1'b0;
            end
            if (w_rd && w_off == 32'd0)       r_bus_rd <= {31'd0, r_p_vld};
            else if (w_rd && w_off == 32'd24) r_bus_rd <= {31'd0, w_done};
            else                              r_bus_rd <= 32'd0;
        end
    end

    // Active job, loop counters, operand buffers and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j_first <= 1'b0; r_j_last <= 1'b0;
            r_j_a <= '0; r_j_b <= '0; r_j_c <= '0; r_j_as <= '0; r_j_bs <= '0;
            r_j_m <= '0; r_j_k <= '0; r_j_n <= '0;
            r_cnt <= '0; r_row <= '0;
            for (int i = 0; i < int'(SYS_COLS); i++) begin
                r_a_row[i] <= '0;
                for (int j = 0; j < int'(SYS_ROWS); j++) r_bbuf[i][j] <= '0;
            end
            for (int i = 0; i < int'(TILE_M); i++)
                for (int j = 0; j < int'(SYS_ROWS); j++) r_acc[i][j] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_j_first <= r_p_first; r_j_last <= r_p_last;
                        r_j_a <= r_p_a; r_j_b <= r_p_b; r_j_c <= r_p_c;
                        r_j_as <= r_p_as; r_j_bs <= r_p_bs;
                        r_j_m <= r_p_m; r_j_k <= r_p_k; r_j_n <= r_p_n;
                        r_cnt <= '0;
                        r_row <= '0;
                    end
                end
                S_BWAIT: begin
                    if (r_rd_vld) begin
                        for (int j = 0; j < int'(SYS_ROWS); j++)
                            r_bbuf[w_brow][j] <= interface_rd_data[8*j +: 8];
                        r_cnt <= w_k_end ? 5'd0 : r_cnt + 5'd1;
                    end
                end
                S_AWAIT: begin
                    if (r_rd_vld) begin
                        for (int k = 0; k < int'(SYS_COLS); k++)
                            r_a_row[k] <= interface_rd_data[8*k +: 8];
                        r_cnt <= '0;
                    end
                end
                S_MAC: begin
                    for (int j = 0; j < int'(SYS_ROWS); j++) begin
                        if (5'(j) < r_j_n)
                            r_acc[r_row[3:0]][j] <= (w_clr ? 32'd0 : r_acc[r_row[3:0]][j]) +
                                32'(r_a_row[r_cnt[3:0]]) * 32'(r_bbuf[r_cnt[3:0]][j]);
                    end
                    if (w_k_end) begin
                        r_cnt <= '0;
                        r_row <= w_m_end ? 5'd0 : r_row + 5'd1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_WB: begin
                    if (w_b_end) begin
                        r_cnt <= '0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered memory interface; read data is valid the cycle after a registered read request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_en <= 1'b0; r_if_rdwr <= 1'b0; r_if_addr <= '0; r_if_ctl <= '0;
            r_if_wdata <= '0; r_rd_vld <= 1'b0;
        end else begin
            r_if_en    <= w_req_en;
            r_if_rdwr  <= w_req_rdwr;
            r_if_addr  <= w_req_addr;
            r_if_ctl   <= w_req_ctl;
            r_if_wdata <= w_req_data;
            r_rd_vld   <= r_if_en && !r_if_rdwr;
        end
    end

    assign system_bus_rd_data = r_bus_rd;
    assign interface_en       = r_if_en;
    assign interface_rdwr     = r_if_rdwr;
    assign interface_addr     = r_if_addr;
    assign interface_control  = r_if_ctl;
    assign interface_wr_data  = r_if_wdata;

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Scoreboard bench for gemm_tile_engine: a reference GEMM model queues expected C beats at launch.
module tb_gemm_tile_engine;
    localparam logic [31:0] BASE = 32'h9000_0000;

    typedef struct packed {
        logic [31:0]  addr;
        logic [4:0]   ctl;
        logic [127:0] data;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sb_en = 1'b0, sb_rdwr = 1'b0;
    logic [31:0]  sb_addr = '0, sb_wdata = '0;
    logic [31:0]  sb_rdata;
    logic         if_en, if_rdwr;
    logic [31:0]  if_addr;
    logic [4:0]   if_ctl;
    logic [127:0] if_rdata = '0;
    logic [127:0] if_wdata;

    logic [7:0]   mem [4096];
    logic [31:0]  cm [16][16];
    beat_t        q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    gemm_tile_engine dut (
        .clk(clk), .rst(rst),
        .system_bus_en(sb_en), .system_bus_rdwr(sb_rdwr), .system_bus_addr(sb_addr),
        .system_bus_wr_data(sb_wdata), .system_bus_rd_data(sb_rdata),
        .interface_en(if_en), .interface_rdwr(if_rdwr), .interface_addr(if_addr),
        .interface_control(if_ctl), .interface_rd_data(if_rdata), .interface_wr_data(if_wdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, bytes beyond the requested count return 0.
    always @(posedge clk) begin
        if (if_en && !if_rdwr) begin
            for (int b = 0; b < 16; b++)
                if_rdata[8*b +: 8] <= (b < int'(if_ctl)) ? mem[12'(if_addr + 32'(b))] : 8'd0;
        end
    end

    // Every write beat must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst && if_en && if_rdwr) begin
            beat_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got addr=%h ctl=%0d, want no write", if_addr, if_ctl);
            end else begin
                e = q.pop_front();
                if ({if_addr, if_ctl, if_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL wb_beat: got addr=%h ctl=%0d data=%h, want addr=%h ctl=%0d data=%h",
                             if_addr, if_ctl, if_wdata, e.addr, e.ctl, e.data);
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        sb_en = 1'b1; sb_rdwr = 1'b1; sb_addr = BASE + off; sb_wdata = d;
        @(negedge clk);
        sb_en = 1'b0; sb_rdwr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        sb_en = 1'b1; sb_rdwr = 1'b0; sb_addr = BASE + off;
        @(negedge clk);
        sb_en = 1'b0;
        d = sb_rdata;
    endtask

    // Reference model: updates retained accumulators and queues expected write beats.
    task automatic push_job(input logic [31:0] a, b, c, as_, bs, input bit first, last,
                            input int m, k, n);
        beat_t e;
        logic [31:0] s;
        int nw;
        if (m < 1 || m > 16 || k < 1 || k > 16 || n < 1 || n > 16) return;
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                s = first ? 32'd0 : cm[i][j];
                for (int kk = 0; kk < k; kk++)
                    s = s + 32'(mem[12'(a + 32'(i) * as_ + 32'(kk))]) *
                            32'(mem[12'(b - 32'(k - 1 - kk) * bs + 32'(j))]);
                cm[i][j] = s;
            end
        if (!last) return;
        for (int i = 0; i < m; i++)
            for (int bt = 0; bt < (n + 3) / 4; bt++) begin
                nw = (n - 4 * bt > 4) ? 4 : n - 4 * bt;
                e.addr = c + 32'(4 * (i * int'(bs) + 4 * bt));
                e.ctl  = 5'(4 * nw);
                e.data = '0;
                for (int w = 0; w < nw; w++) e.data[32*w +: 32] = cm[i][4*bt + w];
                q.push_back(e);
            end
    endtask

    task automatic launch(input logic [31:0] a, b, c, as_, bs, input bit first, last,
                          input int m, k, n, input bit taken);
        bus_write(0, a);   bus_write(4, b);   bus_write(8, c);
        bus_write(12, as_); bus_write(16, bs);
        bus_write(20, {30'd0, first, last});
        if (taken) push_job(a, b, c, as_, bs, first, last, m, k, n);
        bus_write(24, {17'd0, 5'(n), 5'(k), 5'(m)});
    endtask

    task automatic poll_free(input string name);
        logic [31:0] d;
        for (int t = 0; t < 3000; t++) begin
            bus_read(0, d);
            if (d == 32'd0) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL %s_poll_full: got full=1 after budget, want 0", name);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] d = 32'd0;
        for (int t = 0; t < 5000 && d != 32'd1; t++) bus_read(24, d);
        n_cmp++;
        if (d !== 32'd1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d, want 1", name, d);
        end
        n_cmp++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d beats outstanding, want 0", name, q.size());
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 100));
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({if_en, if_rdwr, if_ctl, if_addr, if_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b ctl=%0d addr=%h, want all 0", if_en, if_ctl, if_addr);
        end
        bus_read(0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_full: got %0d, want 0", d); end
        bus_read(24, d);
        n_cmp++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL reset_done: got %0d, want 1", d); end
        bus_read(8, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_other_rd: got %0d, want 0", d); end
    endtask

    task automatic test_single_ones();
        for (int i = 0; i < 16; i++) begin mem[i] = 8'd1; mem[12'h400 + i] = 8'd1; end
        poll_free("ones");
        launch(32'h0, 32'h40C, 32'h800, 32'd4, 32'd4, 1'b1, 1'b1, 4, 4, 4, 1'b1);
        n_cmp++;
        if (q.size() !== 4 || q[0].data !== {32'd4, 32'd4, 32'd4, 32'd4} || q[0].ctl !== 5'd16) begin
            n_fail++;
            $display("FAIL ones_model: got %0d beats data=%h, want 4 beats of word 4", q.size(), q[0].data);
        end
        wait_done("ones");
    endtask

    task automatic test_full_random();
        fill_rand();
        poll_free("full16");
        launch(32'h0, 32'h4F0, 32'h1000, 32'd16, 32'd16, 1'b1, 1'b1, 16, 16, 16, 1'b1);
        wait_done("full16");
    endtask

    task automatic test_ksplit();
        int k0;
        fill_rand();
        for (int t = 0; t < 3; t++) begin
            k0 = 16 * t;
            poll_free("ksplit");
            launch(32'(k0), 32'h400 + 32'((k0 + ((t == 2) ? 8 : 16) - 1) * 8), 32'h2000,
                   32'd40, 32'd8, t == 0, t == 2, 4, (t == 2) ? 8 : 16, 8, 1'b1);
        end
        wait_done("ksplit");
    endtask

    task automatic test_nsize5();
        fill_rand();
        poll_free("n5");
        launch(32'h0, 32'h40A, 32'h3000, 32'd3, 32'd5, 1'b1, 1'b1, 2, 3, 5, 1'b1);
        n_cmp++;
        if (q.size() !== 4 || q[1].ctl !== 5'd4 || q[1].data[127:32] !== 96'd0) begin
            n_fail++;
            $display("FAIL n5_model: got %0d beats ctl=%0d, want 4 beats, 2nd ctl 4", q.size(), q[1].ctl);
        end
        wait_done("n5");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        fill_rand();
        poll_free("b2b");
        launch(32'h0, 32'h4F0, 32'h4000, 32'd16, 32'd16, 1'b1, 1'b1, 16, 16, 16, 1'b1);
        repeat (4) @(negedge clk);
        launch(32'h0, 32'h402, 32'h5000, 32'd2, 32'd2, 1'b1, 1'b1, 2, 2, 2, 1'b1);
        bus_read(0, d);
        n_cmp++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL b2b_full: got %0d, want 1", d); end
        launch(32'h0, 32'h402, 32'h6000, 32'd2, 32'd2, 1'b1, 1'b1, 2, 2, 2, 1'b0);
        bus_read(24, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL b2b_busy: got done=%0d, want 0", d); end
        wait_done("b2b");
    endtask

    task automatic test_zero_dims();
        poll_free("zero");
        launch(32'h0, 32'h400, 32'h7000, 32'd4, 32'd4, 1'b1, 1'b1, 4, 4, 0, 1'b1);
        poll_free("zero");
        launch(32'h0, 32'h400, 32'h7000, 32'd4, 32'd4, 1'b1, 1'b1, 17, 4, 4, 1'b1);
        wait_done("zero");
    endtask

    task automatic test_reset_mid_compute();
        logic [31:0] d;
        bit seen = 1'b0;
        fill_rand();
        poll_free("rstmid");
        launch(32'h0, 32'h4F0, 32'h8000, 32'd16, 32'd16, 1'b1, 1'b1, 16, 16, 16, 1'b1);
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            seen = if_en && !if_rdwr && (if_addr == 32'd16);
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_reach: got no A row 1 read, want one"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (if_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_en: got %b, want 0", if_en); end
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) cm[i][j] = 32'd0;
        bus_read(0, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_full: got %0d, want 0", d); end
        bus_read(24, d);
        n_cmp++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL rstmid_done: got %0d, want 1", d); end
        launch(32'h0, 32'h400 + 32'(4 * 7), 32'h9000, 32'd5, 32'd7, 1'b1, 1'b1, 3, 5, 7, 1'b1);
        wait_done("rstmid");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) cm[i][j] = 32'd0;
        fill_rand();
        test_reset();
        test_single_ones();
        test_full_random();
        test_ksplit();
        test_nsize5();
        test_back_to_back();
        test_zero_dims();
        test_reset_mid_compute();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
